// File: rtl/play_engine_pkg.sv
// rtl/play_engine_pkg.sv - shared play-control constants, speed and state enums
package play_engine_pkg;

    localparam int ADDR_W_DEF = 23;
    localparam int DATA_W_DEF = 16;
    localparam logic [22:0] CHUNK_WORDS_DEF = 23'h0F_FFFF;
    localparam logic [22:0] CHUNK_BASE_0    = 23'h00_0000;

    typedef enum logic [1:0] {
        SPD_1X     = 2'd0,
        SPD_2X     = 2'd1,
        SPD_HALF   = 2'd2,
        SPD_1X_ALT = 2'd3
    } play_speed_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_READY,
        ST_DONE,
        ST_ARM
    } play_state_t;

    // Half speed plays each sample twice: the first strobe of a pair does not move the address.
    function automatic logic [1:0] speed_step(input play_speed_t spd, input logic rep);
        case (spd)
            SPD_2X:   return 2'd2;
            SPD_HALF: return rep ? 2'd1 : 2'd0;
            default:  return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/play_engine_if.sv
// rtl/play_engine_if.sv - play command, SRAM read port and DAC bundle
interface play_engine_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic              play_start;
    logic [ADDR_W-1:0] play_select;
    logic              play_pause;
    logic              play_stop;
    logic [1:0]        play_speed;
    logic              play_done;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              dac_strobe;
    logic [DATA_W-1:0] dac_data;
    logic              busy;

    modport master (
        output play_start, play_select, play_pause, play_stop, play_speed,
        output mem_ack, mem_rdata, dac_strobe,
        input  play_done, mem_req, mem_addr, dac_data, busy
    );

    modport slave (
        input  play_start, play_select, play_pause, play_stop, play_speed,
        input  mem_ack, mem_rdata, dac_strobe,
        output play_done, mem_req, mem_addr, dac_data, busy
    );
endinterface

// File: rtl/play_addr_gen.sv
// rtl/play_addr_gen.sv - chunk address, speed step, repeat flag and end detect
// PLAY_LOOP_EN: end of chunk reloads the base address instead of holding.
module play_addr_gen
    import play_engine_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] CHUNK_WORDS = ADDR_W'(CHUNK_WORDS_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] select,
    input  play_speed_t       speed,
    output logic [ADDR_W-1:0] addr,
    output logic              hold,
    output logic              at_end
);

    localparam logic [ADDR_W:0] WORDS_EXT = {1'b0, CHUNK_WORDS};
    localparam logic [ADDR_W:0] ONE_EXT   = (ADDR_W+1)'(1);

    logic [ADDR_W-1:0] base;
    logic              rep;
    logic [1:0]        step;
    logic [ADDR_W:0]   next_addr;
    logic [ADDR_W:0]   last_addr;

    // Extra bit keeps a 2x overshoot past the top of the address space comparable.
    assign step      = speed_step(speed, rep);
    assign hold      = (step == 2'd0);
    assign next_addr = {1'b0, addr} + {{(ADDR_W-1){1'b0}}, step};
    assign last_addr = {1'b0, base} + WORDS_EXT - ONE_EXT;
    assign at_end    = !hold && (next_addr > last_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= CHUNK_BASE_0[ADDR_W-1:0];
            base <= CHUNK_BASE_0[ADDR_W-1:0];
            rep  <= 1'b0;
        end else if (load) begin
            addr <= select;
            base <= select;
            rep  <= 1'b0;
        end else if (advance) begin
            rep <= hold;
            if (!hold) begin
`ifdef PLAY_LOOP_EN
                if (at_end)
                    addr <= base;
                else
                    addr <= next_addr[ADDR_W-1:0];
`else
                if (!at_end)
                    addr <= next_addr[ADDR_W-1:0];
`endif
            end
        end
    end

endmodule

// File: rtl/play_engine.sv
// rtl/play_engine.sv - play command responder streaming SRAM samples to the DAC
// PLAY_LOOP_EN: replay the chunk from its base until play_stop, no play_done.
module play_engine
    import play_engine_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] CHUNK_WORDS = ADDR_W'(CHUNK_WORDS_DEF)
) (
    input logic             i_clk,
    input logic             i_rst,
    play_engine_if.slave    bus
);

`ifdef PLAY_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    play_state_t       state;
    logic              done_q;
    logic              req_q;
    logic              busy_q;
    logic [DATA_W-1:0] buffer;
    logic [DATA_W-1:0] dac_q;
    logic [ADDR_W-1:0] addr;
    logic              hold;
    logic              at_end;
    logic              load;
    logic              advance;
    logic              accept;

    assign accept  = bus.dac_strobe && !bus.play_pause;
    assign load    = (state == ST_IDLE) && bus.play_start;
    assign advance = (state == ST_READY) && accept && !bus.play_stop;

    play_addr_gen #(
        .ADDR_W      (ADDR_W),
        .CHUNK_WORDS (CHUNK_WORDS)
    ) u_addr_gen (
        .clk     (i_clk),
        .rst     (i_rst),
        .load    (load),
        .advance (advance),
        .select  (bus.play_select),
        .speed   (play_speed_t'(bus.play_speed)),
        .addr    (addr),
        .hold    (hold),
        .at_end  (at_end)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
            req_q  <= 1'b0;
            busy_q <= 1'b0;
            buffer <= '0;
            dac_q  <= '0;
        end else begin
            done_q <= 1'b0;
            // Stop drops any outstanding request; a late ack then lands in IDLE and is ignored.
            if (bus.play_stop && state != ST_IDLE) begin
                state  <= ST_IDLE;
                req_q  <= 1'b0;
                busy_q <= 1'b0;
                dac_q  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.play_start) begin
                            state  <= ST_FETCH;
                            req_q  <= 1'b1;
                            busy_q <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        if (bus.mem_ack) begin
                            buffer <= bus.mem_rdata;
                            req_q  <= 1'b0;
                            state  <= ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (accept) begin
                            dac_q <= buffer;
                            if (!hold) begin
                                if (at_end && !LOOP_EN) begin
                                    state <= ST_DONE;
                                end else begin
                                    state <= ST_FETCH;
                                    req_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        done_q <= 1'b1;
                        state  <= ST_ARM;
                    end
                    ST_ARM: begin
                        // Wait for the start level to drop so a held start cannot replay the chunk.
                        if (!bus.play_start) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                            dac_q  <= '0;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        req_q  <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.play_done = done_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_addr  = addr;
    assign bus.dac_data  = dac_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_play_engine.sv
// tb/tb_play_engine.sv - scoreboard bench for play_engine with a 4-word chunk
module tb_play_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    play_engine_if #(.ADDR_W(23), .DATA_W(16)) pif ();

    play_engine #(
        .ADDR_W      (23),
        .DATA_W      (16),
        .CHUNK_WORDS (23'd4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (pif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int mem_delay = 0;
    int wait_cnt = 0;
    bit late_ack_req = 1'b0;

    logic [15:0] exp_dac[$];
    logic [22:0] exp_addr[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe seen at a clock edge owes one dac_data value.
    initial begin
        forever begin
            @(posedge clk);
            if (pif.dac_strobe === 1'b1) begin
                #1;
                if (exp_dac.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dac_extra: strobe with no expected sample, dac_data=0x%0h", pif.dac_data);
                end else begin
                    check("dac_data", {16'h0, pif.dac_data}, {16'h0, exp_dac.pop_front()});
                end
            end
        end
    end

    // SRAM model: returns addr+0x100 after mem_delay cycles and checks the requested address.
    initial begin
        pif.mem_ack   = 1'b0;
        pif.mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (pif.mem_ack) begin
                pif.mem_ack = 1'b0;
            end else if (late_ack_req) begin
                pif.mem_ack   = 1'b1;
                pif.mem_rdata = 16'hDEAD;
                late_ack_req  = 1'b0;
            end else if (pif.mem_req === 1'b1) begin
                if (wait_cnt >= mem_delay) begin
                    wait_cnt      = 0;
                    pif.mem_ack   = 1'b1;
                    pif.mem_rdata = pif.mem_addr[15:0] + 16'h100;
                    if (exp_addr.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mem_extra: unexpected read of addr 0x%0h", pif.mem_addr);
                    end else begin
                        check("mem_addr", {9'h0, pif.mem_addr}, {9'h0, exp_addr.pop_front()});
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    always @(negedge clk) if (pif.play_done === 1'b1) done_cnt++;

    task automatic strobe(input logic [15:0] exp, input int gap);
        exp_dac.push_back(exp);
        @(negedge clk) pif.dac_strobe = 1'b1;
        @(negedge clk) pif.dac_strobe = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic start_play(input logic [22:0] base, input logic [1:0] spd, input bit hold_start);
        @(negedge clk);
        pif.play_select = base;
        pif.play_speed  = spd;
        pif.play_start  = 1'b1;
        if (!hold_start) @(negedge clk) pif.play_start = 1'b0;
    endtask

    initial begin
        pif.play_start  = 1'b0;
        pif.play_select = 23'h0;
        pif.play_pause  = 1'b0;
        pif.play_stop   = 1'b0;
        pif.play_speed  = 2'd0;
        pif.dac_strobe  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_play_done", {31'h0, pif.play_done}, 32'h0);
        check("rst_mem_req",   {31'h0, pif.mem_req},   32'h0);
        check("rst_mem_addr",  {9'h0, pif.mem_addr},   32'h0);
        check("rst_dac_data",  {16'h0, pif.dac_data},  32'h0);
        check("rst_busy",      {31'h0, pif.busy},      32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef PLAY_LOOP_EN
        for (int i = 0; i < 4; i++) exp_addr.push_back(23'(i));
        for (int i = 0; i < 3; i++) exp_addr.push_back(23'(i));
        start_play(23'h0, 2'd0, 1'b0);
        repeat (4) @(negedge clk);
        strobe(16'h100, 4);
        strobe(16'h101, 4);
        strobe(16'h102, 4);
        strobe(16'h103, 4);
        strobe(16'h100, 4);
        strobe(16'h101, 4);
        check("loop_busy", {31'h0, pif.busy}, 32'h1);
        @(negedge clk) pif.play_stop = 1'b1;
        @(negedge clk) pif.play_stop = 1'b0;
        check("loop_stop_busy", {31'h0, pif.busy}, 32'h0);
        check("loop_stop_dac", {16'h0, pif.dac_data}, 32'h0);
        repeat (3) @(negedge clk);
        check("loop_no_done", done_cnt, 0);
`else
        // 1x from base 0, start held through the end of the chunk
        for (int i = 0; i < 4; i++) exp_addr.push_back(23'(i));
        start_play(23'h0, 2'd0, 1'b1);
        @(negedge clk);
        check("start_busy", {31'h0, pif.busy}, 32'h1);
        repeat (3) @(negedge clk);
        strobe(16'h100, 4);
        strobe(16'h101, 4);
        strobe(16'h102, 4);
        strobe(16'h103, 4);
        repeat (6) @(negedge clk);
        check("arm_done_once", done_cnt, 1);
        check("arm_busy", {31'h0, pif.busy}, 32'h1);
        check("arm_no_req", {31'h0, pif.mem_req}, 32'h0);
        pif.play_start = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", {31'h0, pif.busy}, 32'h0);
        check("idle_dac", {16'h0, pif.dac_data}, 32'h0);

        // 2x from 0x10: 0x14 would be one past the end and must never be read
        exp_addr.push_back(23'h10);
        exp_addr.push_back(23'h12);
        start_play(23'h10, 2'd1, 1'b0);
        repeat (4) @(negedge clk);
        strobe(16'h110, 4);
        strobe(16'h112, 6);
        check("x2_done", done_cnt, 2);
        check("x2_idle_busy", {31'h0, pif.busy}, 32'h0);

        // 0.5x from 0x20: each sample presented on two strobes
        for (int i = 0; i < 4; i++) exp_addr.push_back(23'h20 + 23'(i));
        start_play(23'h20, 2'd2, 1'b0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            strobe(16'h120 + 16'(i), 4);
            strobe(16'h120 + 16'(i), 4);
        end
        repeat (2) @(negedge clk);
        check("half_done", done_cnt, 3);

        // pause for three strobes after the first sample
        for (int i = 0; i < 4; i++) exp_addr.push_back(23'h30 + 23'(i));
        start_play(23'h30, 2'd0, 1'b0);
        repeat (4) @(negedge clk);
        strobe(16'h130, 4);
        pif.play_pause = 1'b1;
        strobe(16'h130, 2);
        strobe(16'h130, 2);
        strobe(16'h130, 2);
        check("pause_addr", {9'h0, pif.mem_addr}, 32'h31);
        check("pause_no_req", {31'h0, pif.mem_req}, 32'h0);
        pif.play_pause = 1'b0;
        strobe(16'h131, 4);
        strobe(16'h132, 4);
        strobe(16'h133, 6);
        check("pause_done", done_cnt, 4);

        // stop with a slow read outstanding, underrun strobe, then a stray late ack
        exp_addr.push_back(23'h40);
        start_play(23'h40, 2'd0, 1'b0);
        repeat (4) @(negedge clk);
        mem_delay = 5;
        strobe(16'h140, 0);
        check("stop_req_pending", {31'h0, pif.mem_req}, 32'h1);
        strobe(16'h140, 0);
        @(negedge clk) pif.play_stop = 1'b1;
        @(negedge clk) pif.play_stop = 1'b0;
        check("stop_busy", {31'h0, pif.busy}, 32'h0);
        check("stop_dac", {16'h0, pif.dac_data}, 32'h0);
        check("stop_req", {31'h0, pif.mem_req}, 32'h0);
        late_ack_req = 1'b1;
        repeat (4) @(negedge clk);
        check("late_ack_busy", {31'h0, pif.busy}, 32'h0);
        check("late_ack_req", {31'h0, pif.mem_req}, 32'h0);
        check("late_ack_dac", {16'h0, pif.dac_data}, 32'h0);
        check("stop_no_done", done_cnt, 4);
        mem_delay = 0;
`endif

        repeat (4) @(negedge clk);
        check("dac_queue_left", exp_dac.size(), 0);
        check("addr_queue_left", exp_addr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/play_engine.md
# play_engine

Responder end of the control-core play command interface. Accepts play start/stop/pause/speed commands and a chunk base address, streams 16-bit samples out of SRAM through a request/acknowledge read port, and presents them to the audio DAC path, one per DAC sample strobe. It reports completion with a one-cycle done pulse so the control FSM can return to idle.

## Interface
- ADDR_W, 23, SRAM word address width (matches chunk select width)
- DATA_W, 16, sample width
- CHUNK_WORDS, 23'h0F_FFFF, words per chunk; last address = base + CHUNK_WORDS - 1
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- play_start  in  1  level; start request, sampled in IDLE
- play_select  in  ADDR_W  chunk base address, latched at start
- play_pause  in  1  level; freeze address and output
- play_stop  in  1  abort to IDLE
- play_speed  in  2  0 = 1x, 1 = 2x, 2 = 0.5x, 3 = treated as 1x; sampled per output sample
- play_done  out  1  one-cycle pulse at natural end of chunk
- mem_req  out  1  read request, held until mem_ack
- mem_addr  out  ADDR_W  read address, stable while mem_req high
- mem_ack  in  1  one-cycle; mem_rdata valid same cycle
- mem_rdata  in  DATA_W  read data
- dac_strobe  in  1  one-cycle pulse per DAC sample period
- dac_data  out  DATA_W  current output sample
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, FETCH, READY, DONE, ARM.
- IDLE: dac_data = 0. play_start high -> latch base into addr and base registers, go FETCH.
- FETCH: mem_req = 1, mem_addr = addr. On mem_ack: capture mem_rdata into sample buffer, go READY.
- READY: on dac_strobe with play_pause low: dac_data <= buffer; advance addr by speed (1x: +1, 2x: +2, 0.5x: +1 on every second strobe, repeat flag toggles); if new addr is past last address go DONE, else go FETCH (0.5x repeat strobe stays in READY, no fetch).
- 2x advance overshooting last address by one counts as end; never read past last address.
- DONE: play_done = 1 for one cycle, go ARM.
- ARM: wait for play_start low, then IDLE (prevents re-trigger on held level).
- play_pause high: dac_strobe ignored, dac_data holds, addr holds; an outstanding mem_req completes normally.
- play_stop: priority over all, any state except IDLE -> IDLE next cycle, dac_data <= 0, no play_done. If mem_req was outstanding, request drops; a late mem_ack in IDLE is ignored.
- dac_strobe in FETCH (underrun): dac_data holds previous sample, strobe not counted.
- Address arithmetic ADDR_W bits unsigned, computed with one extra bit for end compare; no wrap into next chunk.

## Timing
- Reset: state IDLE, play_done 0, mem_req 0, mem_addr 0, dac_data 0, busy 0, repeat flag 0.
- play_start high in IDLE -> mem_req high next cycle.
- mem_ack -> READY next cycle; dac_data updates the cycle after the accepted dac_strobe.
- Last sample strobe -> play_done the cycle after entering DONE (2 cycles after strobe).
- play_stop -> state IDLE and dac_data 0 one cycle later.
- All outputs registered.

## Configuration
- PLAY_LOOP_EN defined: end of chunk reloads addr = base and goes FETCH; no DONE, no play_done; runs until play_stop.
- Undefined: end of chunk behaves as in Operation (DONE, pulse, ARM).

## Structure
- Shared control package holds: chunk base address constants, CHUNK_WORDS default, play speed enum (SPD_1X, SPD_2X, SPD_HALF), play state enum.
- One sub-module natural: play_addr_gen (addr/base registers, speed step, repeat flag, end detect, loop reload).

## Test plan
- Base 23'h000000, CHUNK_WORDS 4, speed 0, memory returns addr+16'h100, 4 strobes -> dac_data 0x100,0x101,0x102,0x103, play_done pulses once, busy low after play_start released.
- Speed 1 (2x), CHUNK_WORDS 5 -> dac_data 0x100,0x102,0x104, then play_done; address 5 never requested.
- Speed 2 (0.5x), CHUNK_WORDS 2 -> dac_data 0x100,0x100,0x101,0x101, then play_done.
- play_pause high for 3 strobes mid-chunk -> dac_data and mem_addr unchanged, resumes at next address after release.
- play_stop while mem_req pending (ack delayed 5 cycles) -> IDLE next cycle, dac_data 0, no play_done, late ack ignored.
- play_start held high after play_done -> stays ARM, no new mem_req until start drops then rises; with PLAY_LOOP_EN, CHUNK_WORDS 2 -> 0x100,0x101,0x100,... and no play_done.
